// File: rtl/ghost_motion_engine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ghost_motion_engine_pkg                                          |
// | Brief   : Shared ghost steering definitions: directions, widths, states.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ghost_motion_engine_pkg;

    localparam int c_POS_X_W   = 11;
    localparam int c_POS_Y_W   = 10;
    localparam int c_DIR_W     = 4;
    localparam int c_STATE_W   = 2;

    // One-hot {LEFT,DOWN,UP,RIGHT}
    localparam logic [c_DIR_W-1:0] c_DIR_RIGHT = 4'b0001;
    localparam logic [c_DIR_W-1:0] c_DIR_UP    = 4'b0010;
    localparam logic [c_DIR_W-1:0] c_DIR_DOWN  = 4'b0100;
    localparam logic [c_DIR_W-1:0] c_DIR_LEFT  = 4'b1000;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_DECIDE = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_MOVE   = 2'd2;

    function automatic logic is_one_hot(input logic [c_DIR_W-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : step_tick_gen                                                    |
// | Brief   : STEP_DIV prescaler with count enable and synchronous clear.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module step_tick_gen #(
    parameter int unsigned STEP_DIV = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 c_CNT_W    = $clog2(STEP_DIV);
    localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(STEP_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    assign o_tick = i_count_en && (r_count == c_TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= o_tick ? '0 : r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ghost_motion_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ghost_motion_engine                                              |
// | Brief   : Ghost position/direction registers; steps one pixel per tick,    |
// |           re-reads move_direction only at tile boundaries.                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ghost_motion_engine
    import ghost_motion_engine_pkg::*;
#(
    parameter logic [c_POS_X_W-1:0] START_X     = 11'd304,
    parameter logic [c_POS_Y_W-1:0] START_Y     = 10'd224,
    parameter int unsigned          STEP_DIV    = 250000,
    parameter int                   TILE_LOG2   = 4,
    parameter logic [c_POS_X_W-1:0] X_WRAP_MAX  = 11'd639,
    parameter logic [c_POS_Y_W-1:0] Y_MAX       = 10'd479,
    parameter int                   DECIDE_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 respawn,
    input  logic [c_DIR_W-1:0]   move_direction,
    output logic [c_POS_X_W-1:0] ghost_pos_x,
    output logic [c_POS_Y_W-1:0] ghost_pos_y,
    output logic [c_DIR_W-1:0]   prev_direction,
    output logic                 moving,
    output logic                 step_pulse
);

    localparam int                  c_WAIT_W    = $clog2(DECIDE_WAIT + 2);
    localparam logic [c_WAIT_W-1:0] c_WAIT_DONE = c_WAIT_W'(DECIDE_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_POS_X_W-1:0] r_pos_x;
    logic [c_POS_Y_W-1:0] r_pos_y;
    logic [c_DIR_W-1:0]   r_prev_dir;
    logic [c_DIR_W-1:0]   r_cur_dir;
    logic                 r_moving;
    logic                 r_step_pulse;
    logic [c_WAIT_W-1:0]  r_wait_cnt;

    logic [c_STATE_W-1:0] w_next_state;
    logic [c_POS_X_W-1:0] w_next_x;
    logic [c_POS_Y_W-1:0] w_next_y;
    logic                 w_step;
    logic                 w_accept;
    logic                 w_tick;

    // Counter is held at zero outside MOVE, so entering MOVE always starts a full period
    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_count_en (enable && (r_state == c_ST_MOVE)),
        .i_clear    (respawn || (r_state != c_ST_MOVE)),
        .o_tick     (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_x     = r_pos_x;
        w_next_y     = r_pos_y;
        w_step       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            c_ST_IDLE: w_next_state = c_ST_DECIDE;
            c_ST_DECIDE: begin
                if ((r_wait_cnt == c_WAIT_DONE) && is_one_hot(move_direction)) begin
                    w_accept     = 1'b1;
                    w_next_state = c_ST_MOVE;
                end
            end
            c_ST_MOVE: begin
                if (w_tick) begin
                    case (r_cur_dir)
                        c_DIR_RIGHT: begin
                            w_step   = 1'b1;
                            w_next_x = (r_pos_x == X_WRAP_MAX) ? '0 : r_pos_x + 11'd1;
                        end
                        c_DIR_LEFT: begin
                            w_step   = 1'b1;
                            w_next_x = (r_pos_x == '0) ? X_WRAP_MAX : r_pos_x - 11'd1;
                        end
                        c_DIR_DOWN: begin
                            if (r_pos_y == Y_MAX) begin
                                w_next_state = c_ST_DECIDE;
                            end else begin
                                w_step   = 1'b1;
                                w_next_y = r_pos_y + 10'd1;
                            end
                        end
                        c_DIR_UP: begin
                            if (r_pos_y == '0) begin
                                w_next_state = c_ST_DECIDE;
                            end else begin
                                w_step   = 1'b1;
                                w_next_y = r_pos_y - 10'd1;
                            end
                        end
                        default: w_next_state = c_ST_DECIDE;
                    endcase
                    if (w_step && (w_next_x[TILE_LOG2-1:0] == '0)
                               && (w_next_y[TILE_LOG2-1:0] == '0)) begin
                        w_next_state = c_ST_DECIDE;
                    end
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_pos_x      <= START_X;
            r_pos_y      <= START_Y;
            r_prev_dir   <= c_DIR_LEFT;
            r_cur_dir    <= c_DIR_LEFT;
            r_moving     <= 1'b0;
            r_step_pulse <= 1'b0;
            r_wait_cnt   <= '0;
        end else if (respawn) begin
            r_state      <= c_ST_IDLE;
            r_pos_x      <= START_X;
            r_pos_y      <= START_Y;
            r_prev_dir   <= c_DIR_LEFT;
            r_cur_dir    <= c_DIR_LEFT;
            r_moving     <= 1'b0;
            r_step_pulse <= 1'b0;
            r_wait_cnt   <= '0;
        end else if (!enable) begin
            r_step_pulse <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pos_x      <= w_next_x;
            r_pos_y      <= w_next_y;
            r_moving     <= (w_next_state == c_ST_MOVE);
            r_step_pulse <= w_step;
            if (w_accept) begin
                r_cur_dir  <= move_direction;
                r_prev_dir <= move_direction;
            end
            // Held at zero outside DECIDE, so every entry restarts the settle wait
            if (r_state != c_ST_DECIDE) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_WAIT_DONE) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
            end
        end
    end

    assign ghost_pos_x    = r_pos_x;
    assign ghost_pos_y    = r_pos_y;
    assign prev_direction = r_prev_dir;
    assign moving         = r_moving;
    assign step_pulse     = r_step_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ghost_motion_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ghost_motion_engine                                           |
// | Brief   : Directed self-checking bench for ghost_motion_engine.            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ghost_motion_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        respawn;
    logic [3:0]  move_direction;
    logic [10:0] ghost_pos_x;
    logic [9:0]  ghost_pos_y;
    logic [3:0]  prev_direction;
    logic        moving;
    logic        step_pulse;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int pulse_q[$];

    ghost_motion_engine #(
        .START_X     (11'd304),
        .START_Y     (10'd224),
        .STEP_DIV    (4),
        .TILE_LOG2   (4),
        .X_WRAP_MAX  (11'd639),
        .Y_MAX       (10'd479),
        .DECIDE_WAIT (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .respawn        (respawn),
        .move_direction (move_direction),
        .ghost_pos_x    (ghost_pos_x),
        .ghost_pos_y    (ghost_pos_y),
        .prev_direction (prev_direction),
        .moving         (moving),
        .step_pulse     (step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_pulse === 1'b1) pulse_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_moving(input logic val, input int limit, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            sample();
            if (moving === val) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_pulse(input int limit, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            sample();
            if (step_pulse === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int base;
        int rise_cyc;
        int bad_gaps;
        int n0;
        int x0;
        int c0;
        bit ok;
        bit seen;

        rst_n          = 1'b0;
        enable         = 1'b0;
        respawn        = 1'b0;
        move_direction = 4'b0000;
        repeat (3) sample();

        chk("rst_x",     32'(ghost_pos_x),    32'd304);
        chk("rst_y",     32'(ghost_pos_y),    32'd224);
        chk("rst_prev",  32'(prev_direction), 32'b1000);
        chk("rst_moving", 32'(moving),        32'd0);
        chk("rst_pulse", 32'(step_pulse),     32'd0);

        // Invalid directions: multi-hot, then zero
        rst_n          = 1'b1;
        enable         = 1'b1;
        move_direction = 4'b0011;
        repeat (10) sample();
        chk("inv_multi_moving", 32'(moving),         32'd0);
        chk("inv_multi_prev",   32'(prev_direction), 32'b1000);
        chk("inv_multi_x",      32'(ghost_pos_x),    32'd304);
        chk("inv_multi_pulses", 32'(pulse_q.size()), 32'd0);
        move_direction = 4'b0000;
        repeat (5) sample();
        chk("inv_zero_moving", 32'(moving),         32'd0);
        chk("inv_zero_prev",   32'(prev_direction), 32'b1000);

        // Straight run right across one tile
        move_direction = 4'b0001;
        wait_moving(1'b1, 10, "run_accept_timeout");
        rise_cyc = cyc;
        base     = pulse_q.size();
        chk("run_prev", 32'(prev_direction), 32'b0001);
        wait_moving(1'b0, 100, "run_finish_timeout");
        move_direction = 4'b0000;
        chk("run_pulses", 32'(pulse_q.size() - base), 32'd16);
        chk("run_x",      32'(ghost_pos_x),           32'd320);
        chk("run_y",      32'(ghost_pos_y),           32'd224);
        if (pulse_q.size() > base) begin
            chk("run_first_latency", 32'(pulse_q[base] - rise_cyc), 32'd4);
        end
        bad_gaps = 0;
        for (int i = base + 1; i < pulse_q.size(); i++) begin
            if (pulse_q[i] - pulse_q[i-1] != 4) bad_gaps++;
        end
        chk("run_gaps", 32'(bad_gaps), 32'd0);

        // Pause mid-tile just after a step
        move_direction = 4'b0001;
        wait_moving(1'b1, 10, "pause_accept_timeout");
        wait_pulse(10, "pause_step_timeout");
        enable = 1'b0;
        x0     = int'(ghost_pos_x);
        n0     = pulse_q.size();
        seen   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (step_pulse === 1'b1) seen = 1'b1;
        end
        chk("pause_x",      32'(ghost_pos_x),    32'(x0));
        chk("pause_pulses", 32'(pulse_q.size()), 32'(n0));
        chk("pause_seen",   32'(seen),           32'd0);
        chk("pause_moving", 32'(moving),         32'd1);
        enable = 1'b1;
        c0     = cyc;
        wait_pulse(10, "resume_step_timeout");
        chk("resume_latency", 32'(cyc - c0),      32'd4);
        chk("resume_x",       32'(ghost_pos_x),   32'(x0 + 1));

        // Respawn asserted on a tick cycle
        repeat (3) sample();
        respawn = 1'b1;
        sample();
        chk("respawn_x",      32'(ghost_pos_x),    32'd304);
        chk("respawn_y",      32'(ghost_pos_y),    32'd224);
        chk("respawn_pulse",  32'(step_pulse),     32'd0);
        chk("respawn_moving", 32'(moving),         32'd0);
        chk("respawn_prev",   32'(prev_direction), 32'b1000);
        respawn        = 1'b0;
        move_direction = 4'b1000;

        // Tunnel: run left to x=0, then wrap
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            sample();
            if (ghost_pos_x == 11'd0 && moving == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tunnel_reach0", 32'(ok), 32'd1);
        wait_pulse(20, "tunnel_left_timeout");
        chk("tunnel_left_x", 32'(ghost_pos_x), 32'd639);
        wait_moving(1'b0, 100, "tunnel_left_tile_timeout");
        chk("tunnel_tile_x", 32'(ghost_pos_x), 32'd624);
        move_direction = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            sample();
            if (step_pulse === 1'b1 && ghost_pos_x == 11'd639) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tunnel_reach639", 32'(ok), 32'd1);
        wait_pulse(10, "tunnel_right_timeout");
        chk("tunnel_right_x",      32'(ghost_pos_x), 32'd0);
        chk("tunnel_right_moving", 32'(moving),      32'd0);

        // Wall: climb to y=0, then UP again must not step
        respawn        = 1'b1;
        sample();
        respawn        = 1'b0;
        move_direction = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            sample();
            if (ghost_pos_y == 10'd0 && moving == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wall_reach0", 32'(ok), 32'd1);
        wait_moving(1'b1, 10, "wall_accept_timeout");
        n0 = pulse_q.size();
        wait_moving(1'b0, 10, "wall_decide_timeout");
        chk("wall_y",      32'(ghost_pos_y),    32'd0);
        chk("wall_x",      32'(ghost_pos_x),    32'd304);
        chk("wall_pulses", 32'(pulse_q.size()), 32'(n0));
        chk("wall_prev",   32'(prev_direction), 32'b0010);

        // Asynchronous reset mid-MOVE
        move_direction = 4'b0100;
        wait_moving(1'b1, 10, "arst_accept_timeout");
        repeat (6) sample();
        rst_n = 1'b0;
        #1;
        chk("arst_x",      32'(ghost_pos_x),    32'd304);
        chk("arst_y",      32'(ghost_pos_y),    32'd224);
        chk("arst_prev",   32'(prev_direction), 32'b1000);
        chk("arst_moving", 32'(moving),         32'd0);
        repeat (2) sample();
        rst_n = 1'b1;
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
